// File: rtl/atm_session_ctrl_if.sv
// Request/response bundle between an ATM front panel and its session controller.
// The master side drives requests; the slave side is the session controller.
interface atm_session_ctrl_if #(
    parameter int unsigned CREDIT_W = 16,
    parameter int unsigned CARD_W   = 3,
    parameter int unsigned PASS_W   = 16
);
    logic                init_we;
    logic [CARD_W-1:0]   init_idx;
    logic [CREDIT_W-1:0] init_credit;
    logic [PASS_W-1:0]   init_pass;
    logic                insert;
    logic [CARD_W-1:0]   card_idx;
    logic [PASS_W-1:0]   password;
    logic                enter;
    logic                cancel;
    logic [1:0]          op;
    logic [CREDIT_W-1:0] amount;
    logic [CARD_W-1:0]   dest_idx;
    logic [CREDIT_W-1:0] balance_out;
    logic                done;
    logic                abort;
    logic                card_out;
    logic                locked;

    modport master (
        output init_we, init_idx, init_credit, init_pass, insert, card_idx,
               password, enter, cancel, op, amount, dest_idx,
        input  balance_out, done, abort, card_out, locked
    );

    modport slave (
        input  init_we, init_idx, init_credit, init_pass, insert, card_idx,
               password, enter, cancel, op, amount, dest_idx,
        output balance_out, done, abort, card_out, locked
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card insert, PIN check with lockout, banking
// operations on an internal account table, idle timeout and card eject.
module atm_session_ctrl #(
    parameter int unsigned CREDIT_W  = 16,
    parameter int unsigned CARD_W    = 3,
    parameter int unsigned PASS_W    = 16,
    parameter int unsigned MAX_TRIES = 3,
    parameter int unsigned WD_LIMIT  = 1000,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic              clk,
    input logic              rst_n,
    atm_session_ctrl_if.slave bus
);
    localparam int unsigned NUM_CARDS = 2**CARD_W;

    typedef enum logic [1:0] {S_IDLE, S_PIN, S_MENU, S_EJECT} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CREDIT_W-1:0] r_credit [NUM_CARDS];
    logic [PASS_W-1:0]   r_pass   [NUM_CARDS];
    logic                r_lock   [NUM_CARDS];
    logic [CARD_W-1:0]   r_active;
    logic [2:0]          r_tries;
    logic [15:0]         r_idle;
    logic [CREDIT_W-1:0] r_balance;
    logic                r_done;
    logic                r_abort;

    logic [CREDIT_W-1:0] w_cur;
    logic [CREDIT_W-1:0] w_dst;
    logic [CREDIT_W:0]   w_dep_sum;
    logic [CREDIT_W:0]   w_dst_sum;
    logic                w_wd_bad;
    logic                w_timeout;
    logic                w_pin_ok;
    logic                w_last_try;
    logic                w_op_ok;
    logic                w_card_out;
    logic                w_locked;

    assign w_cur      = r_credit[r_active];
    assign w_dst      = r_credit[bus.dest_idx];
    assign w_dep_sum  = {1'b0, w_cur} + {1'b0, bus.amount};
    assign w_dst_sum  = {1'b0, w_dst} + {1'b0, bus.amount};
    assign w_wd_bad   = (bus.amount > w_cur) || (32'(bus.amount) > WD_LIMIT);
    assign w_timeout  = !bus.cancel && !bus.enter && (r_idle == 16'(TIMEOUT - 1));
    assign w_pin_ok   = (bus.password == r_pass[r_active]);
    assign w_last_try = (r_tries == 3'(MAX_TRIES - 1));

    always_comb begin
        w_op_ok = 1'b0;
        case (bus.op)
            2'd0:    w_op_ok = 1'b1;
            2'd1:    w_op_ok = !w_dep_sum[CREDIT_W];
            2'd2:    w_op_ok = !w_wd_bad;
            default: w_op_ok = (bus.dest_idx != r_active) && !r_lock[bus.dest_idx] &&
                               !w_wd_bad && !w_dst_sum[CREDIT_W];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.insert) w_next = r_lock[bus.card_idx] ? S_EJECT : S_PIN;
            end
            S_PIN: begin
                if (bus.cancel)     w_next = S_EJECT;
                else if (bus.enter) w_next = w_pin_ok ? S_MENU : (w_last_try ? S_EJECT : S_PIN);
                else if (w_timeout) w_next = S_EJECT;
            end
            S_MENU: begin
                if (bus.cancel || w_timeout) w_next = S_EJECT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_card_out = (r_state == S_EJECT);
        w_locked   = (r_state != S_IDLE) && r_lock[r_active];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CARDS; i++) begin
                r_credit[i] <= '0;
                r_pass[i]   <= '0;
                r_lock[i]   <= 1'b0;
            end
            r_active  <= '0;
            r_tries   <= '0;
            r_idle    <= '0;
            r_balance <= '0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tries <= '0;
                    r_idle  <= '0;
                    if (bus.init_we) begin
                        r_credit[bus.init_idx] <= bus.init_credit;
                        r_pass[bus.init_idx]   <= bus.init_pass;
                        r_lock[bus.init_idx]   <= 1'b0;
                    end
                    if (bus.insert) begin
                        r_active <= bus.card_idx;
                        if (r_lock[bus.card_idx]) r_abort <= 1'b1;
                    end
                end
                S_PIN: begin
                    if (bus.cancel) begin
                        r_idle <= '0;
                    end else if (bus.enter) begin
                        r_idle <= '0;
                        if (w_pin_ok) begin
                            r_tries <= '0;
                        end else begin
                            r_tries <= r_tries + 3'd1;
                            if (w_last_try) begin
                                r_lock[r_active] <= 1'b1;
                                r_abort          <= 1'b1;
                            end
                        end
                    end else if (w_timeout) begin
                        r_abort <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 16'd1;
                    end
                end
                S_MENU: begin
                    if (bus.cancel) begin
                        r_idle <= '0;
                    end else if (bus.enter) begin
                        r_idle  <= '0;
                        r_done  <= w_op_ok;
                        r_abort <= !w_op_ok;
                        if (w_op_ok) begin
                            // Transfer debits active and credits dest in one cycle; indices differ.
                            case (bus.op)
                                2'd0: r_balance <= w_cur;
                                2'd1: begin
                                    r_credit[r_active] <= w_dep_sum[CREDIT_W-1:0];
                                    r_balance          <= w_dep_sum[CREDIT_W-1:0];
                                end
                                2'd2: begin
                                    r_credit[r_active] <= w_cur - bus.amount;
                                    r_balance          <= w_cur - bus.amount;
                                end
                                default: begin
                                    r_credit[r_active]     <= w_cur - bus.amount;
                                    r_credit[bus.dest_idx] <= w_dst_sum[CREDIT_W-1:0];
                                    r_balance              <= w_cur - bus.amount;
                                end
                            endcase
                        end
                    end else if (w_timeout) begin
                        r_abort <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 16'd1;
                    end
                end
                default: begin
                    r_balance <= '0;
                    r_tries   <= '0;
                end
            endcase
        end
    end

    assign bus.balance_out = r_balance;
    assign bus.done        = r_done;
    assign bus.abort       = r_abort;
    assign bus.card_out    = w_card_out;
    assign bus.locked      = w_locked;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed and randomized checks of atm_session_ctrl against an account-level
// reference model (plain integer arithmetic on per-card arrays).
module tb_atm_session_ctrl;
    localparam int unsigned TB_TIMEOUT = 20;
    localparam int unsigned MAXT       = 3;
    localparam int unsigned WD         = 1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    atm_session_ctrl_if #(.CREDIT_W(16), .CARD_W(3), .PASS_W(16)) bus ();

    atm_session_ctrl #(
        .CREDIT_W(16), .CARD_W(3), .PASS_W(16),
        .MAX_TRIES(MAXT), .WD_LIMIT(WD), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned m_credit [8];
    int unsigned m_pass   [8];
    bit          m_lock   [8];
    int unsigned m_active = 0;
    int unsigned m_tries  = 0;
    int unsigned m_bal    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_credit[i] = 0;
            m_pass[i]   = 0;
            m_lock[i]   = 1'b0;
        end
        m_bal   = 0;
        m_tries = 0;
    endtask

    task automatic load(input int unsigned idx, input int unsigned cr, input int unsigned pw);
        bus.init_we     = 1'b1;
        bus.init_idx    = 3'(idx);
        bus.init_credit = 16'(cr);
        bus.init_pass   = 16'(pw);
        step();
        bus.init_we = 1'b0;
        m_credit[idx] = cr;
        m_pass[idx]   = pw;
        m_lock[idx]   = 1'b0;
    endtask

    task automatic insert_card(input int unsigned idx);
        bus.insert   = 1'b1;
        bus.card_idx = 3'(idx);
        step();
        bus.insert = 1'b0;
        m_active = idx;
        m_tries  = 0;
        chk("insert_abort", bus.abort, m_lock[idx]);
        chk("insert_card_out", bus.card_out, m_lock[idx]);
        chk("insert_locked", bus.locked, m_lock[idx]);
        if (m_lock[idx]) begin
            step();
            m_bal = 0;
            chk("locked_eject_done", bus.card_out, 1'b0);
        end
    endtask

    task automatic enter_pin(input int unsigned pw);
        bus.password = 16'(pw);
        bus.enter    = 1'b1;
        step();
        bus.enter = 1'b0;
        if (pw == m_pass[m_active]) begin
            m_tries = 0;
            chk("pin_ok_abort", bus.abort, 1'b0);
            chk("pin_ok_card_out", bus.card_out, 1'b0);
        end else begin
            m_tries++;
            if (m_tries == MAXT) begin
                m_lock[m_active] = 1'b1;
                chk("lockout_abort", bus.abort, 1'b1);
                chk("lockout_card_out", bus.card_out, 1'b1);
                chk("lockout_locked", bus.locked, 1'b1);
                step();
                m_bal = 0;
                chk("lockout_idle_card_out", bus.card_out, 1'b0);
                chk("lockout_idle_locked", bus.locked, 1'b0);
            end else begin
                chk("pin_bad_abort", bus.abort, 1'b0);
                chk("pin_bad_card_out", bus.card_out, 1'b0);
            end
        end
    endtask

    task automatic do_op(input int unsigned o, input int unsigned amt, input int unsigned d);
        int unsigned cur;
        bit          ok;
        bus.op       = 2'(o);
        bus.amount   = 16'(amt);
        bus.dest_idx = 3'(d);
        bus.enter    = 1'b1;
        step();
        bus.enter = 1'b0;
        cur = m_credit[m_active];
        case (o)
            0:       ok = 1'b1;
            1:       ok = (cur + amt <= 65535);
            2:       ok = (amt <= cur) && (amt <= WD);
            default: ok = (d != m_active) && !m_lock[d] && (amt <= cur) && (amt <= WD) &&
                          (m_credit[d] + amt <= 65535);
        endcase
        if (ok) begin
            if (o == 1) m_credit[m_active] = cur + amt;
            if (o == 2) m_credit[m_active] = cur - amt;
            if (o == 3) begin
                m_credit[m_active] = cur - amt;
                m_credit[d]        = m_credit[d] + amt;
            end
            m_bal = m_credit[m_active];
        end
        chk($sformatf("op%0d_done", o), bus.done, ok);
        chk($sformatf("op%0d_abort", o), bus.abort, !ok);
        chk($sformatf("op%0d_balance", o), bus.balance_out, m_bal);
    endtask

    task automatic cancel_session(input bit with_enter);
        bus.cancel = 1'b1;
        bus.enter  = with_enter;
        bus.op     = 2'd1;
        bus.amount = 16'd1;
        step();
        bus.cancel = 1'b0;
        bus.enter  = 1'b0;
        chk("cancel_done", bus.done, 1'b0);
        chk("cancel_abort", bus.abort, 1'b0);
        chk("cancel_card_out", bus.card_out, 1'b1);
        step();
        m_bal = 0;
        chk("cancel_idle_card_out", bus.card_out, 1'b0);
        chk("cancel_idle_balance", bus.balance_out, 16'd0);
    endtask

    function automatic int unsigned pick_amt(input int unsigned cur);
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return $urandom_range(0, 1100);
            2:       return cur;
            default: return $urandom_range(0, 65535);
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_balance"}, bus.balance_out, 16'd0);
        chk({tag, "_done"}, bus.done, 1'b0);
        chk({tag, "_abort"}, bus.abort, 1'b0);
        chk({tag, "_card_out"}, bus.card_out, 1'b0);
        chk({tag, "_locked"}, bus.locked, 1'b0);
    endtask

    initial begin
        int seen;
        int unsigned card;
        rst_n           = 1'b0;
        bus.init_we     = 1'b0;
        bus.init_idx    = '0;
        bus.init_credit = '0;
        bus.init_pass   = '0;
        bus.insert      = 1'b0;
        bus.card_idx    = '0;
        bus.password    = '0;
        bus.enter       = 1'b0;
        bus.cancel      = 1'b0;
        bus.op          = '0;
        bus.amount      = '0;
        bus.dest_idx    = '0;
        model_clear();
        step();
        step();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // Basic withdraw, refusals and transfer
        load(2, 500, 16'h1234);
        load(5, 0, 16'h5555);
        load(3, 5000, 16'h0003);
        load(4, 16'hFFFF, 16'h0004);
        insert_card(2);
        enter_pin(16'h1234);
        do_op(2, 200, 0);
        do_op(1, 200, 0);
        do_op(0, 0, 0);
        do_op(2, 600, 0);
        do_op(3, 100, 5);
        do_op(3, 10, 2);
        do_op(2, 0, 0);
        do_op(3, 0, 5);
        // init_we and insert outside IDLE must be ignored
        bus.init_we     = 1'b1;
        bus.init_idx    = 3'd2;
        bus.init_credit = 16'd7;
        bus.insert      = 1'b1;
        bus.card_idx    = 3'd4;
        step();
        bus.init_we = 1'b0;
        bus.insert  = 1'b0;
        chk("ignored_abort", bus.abort, 1'b0);
        do_op(0, 0, 0);
        cancel_session(1'b1);

        insert_card(5);
        enter_pin(16'h5555);
        do_op(0, 0, 0);
        cancel_session(1'b0);

        insert_card(3);
        enter_pin(16'h0003);
        do_op(2, 1001, 0);
        do_op(2, 1000, 0);
        do_op(3, 1001, 5);
        cancel_session(1'b0);

        insert_card(4);
        enter_pin(16'h0004);
        do_op(1, 1, 0);
        do_op(1, 0, 0);
        do_op(3, 1, 5);
        cancel_session(1'b0);

        // Lockout and locked reinsert
        insert_card(2);
        enter_pin(16'h1111);
        enter_pin(16'h2222);
        enter_pin(16'h3333);
        insert_card(2);
        insert_card(5);
        enter_pin(16'h5555);
        do_op(3, 1, 2);
        cancel_session(1'b0);

        // Idle timeout in MENU
        insert_card(5);
        enter_pin(16'h5555);
        seen = 0;
        for (int i = 0; i < int'(TB_TIMEOUT) - 1; i++) begin
            step();
            if (bus.abort || bus.card_out) seen++;
        end
        chk("timeout_early", 32'(seen), 32'd0);
        step();
        chk("timeout_abort", bus.abort, 1'b1);
        chk("timeout_card_out", bus.card_out, 1'b1);
        step();
        m_bal = 0;
        chk("timeout_idle", bus.card_out, 1'b0);
        chk("timeout_balance", bus.balance_out, 16'd0);

        // Randomized sessions
        for (int i = 0; i < 8; i++) load(i, $urandom_range(0, 65535), $urandom_range(0, 65535));
        for (int s = 0; s < 8; s++) begin
            card = $urandom_range(0, 7);
            insert_card(card);
            if ($urandom_range(0, 2) == 0) enter_pin(m_pass[card] ^ 1);
            enter_pin(m_pass[card]);
            for (int k = 0; k < 8; k++)
                do_op($urandom_range(0, 3), pick_amt(m_credit[m_active]), $urandom_range(0, 7));
            cancel_session(1'($urandom_range(0, 1)));
        end

        // Reset mid-transaction discards the pending deposit
        insert_card(3);
        enter_pin(m_pass[3]);
        bus.op     = 2'd1;
        bus.amount = 16'd5;
        bus.enter  = 1'b1;
        rst_n      = 1'b0;
        step();
        bus.enter = 1'b0;
        model_clear();
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        step();
        insert_card(3);
        enter_pin(0);
        do_op(0, 0, 0);
        do_op(2, 1, 0);
        cancel_session(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog: simulation did not finish in time");
    end
endmodule
